mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter granting 4 requesters access to one shared sequential
// 16x16 signed multiplier, with a BUSY timeout that aborts a stalled multiply.
module mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   op_a,
  input  logic [16*NREQ-1:0]   op_b,
  output logic [NREQ-1:0]      ack,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [15:0]          mul_in1,
  output logic [15:0]          mul_in2,
  input  logic [31:0]          mul_result,
  input  logic                 mul_finished
);

  localparam int unsigned IW = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] ack_n;
  logic            rsp_valid_n, rsp_err_n, busy_n, mul_start_n;
  logic [IW-1:0]   rsp_id_n;
  logic [RW-1:0]   rsp_data_n;
  logic [DW-1:0]   mul_in1_n, mul_in2_n;

  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   idx;

  // First set request bit at or above ptr, wrapping modulo 4
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // State register plus all registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_in1   <= '0;
      mul_in2   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      ack       <= ack_n;
      rsp_valid <= rsp_valid_n;
      rsp_id    <= rsp_id_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
      busy      <= busy_n;
      mul_start <= mul_start_n;
      mul_in1   <= mul_in1_n;
      mul_in2   <= mul_in2_n;
    end
  end

  // Next state and next register values; pulses default low, payload holds
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    ack_n       = '0;
    rsp_valid_n = 1'b0;
    mul_start_n = 1'b0;
    rsp_id_n    = rsp_id;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    mul_in1_n   = mul_in1;
    mul_in2_n   = mul_in2;

    case (state)
      S_IDLE: begin
        if (found) begin
          ack_n[winner] = 1'b1;
          mul_in1_n     = op_a[{winner, 4'b0000} +: DW];
          mul_in2_n     = op_b[{winner, 4'b0000} +: DW];
          rsp_id_n      = winner;
          ptr_n         = winner + IW'(1);
          mul_start_n   = 1'b1;
          state_n       = S_START;
        end
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_BUSY;
      end
      S_BUSY: begin
        // A completion on the timeout edge still counts as a good result
        if (mul_finished) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = mul_result;
          state_n     = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
          state_n     = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: table of grant/multiply transactions checked through
// an expected-response queue, plus reset-mid-BUSY and stray-finish sequences.
module tb_mul_arbiter;

  localparam int unsigned TIMEOUT = 40;

  logic        sys_clk, sys_rst;
  logic [3:0]  req;
  logic [63:0] op_a, op_b;
  logic [3:0]  ack;
  logic        rsp_valid, rsp_err, busy, mul_start;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [15:0] mul_in1, mul_in2;
  logic [31:0] mul_result;
  logic        mul_finished;

  mul_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start), .mul_in1(mul_in1),
    .mul_in2(mul_in2), .mul_result(mul_result), .mul_finished(mul_finished)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Sequential multiplier model: finishes lat edges after seeing mul_start, lat=0 never
  int   lat;
  int   mcnt;
  logic fin_q, stray;
  logic [31:0] res_q;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mcnt  <= 0;
      fin_q <= 1'b0;
      res_q <= '0;
    end else begin
      fin_q <= 1'b0;
      if (mul_start) mcnt <= lat;
      else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          fin_q <= 1'b1;
          res_q <= 32'(int'($signed(mul_in1)) * int'($signed(mul_in2)));
        end
      end
    end
  end

  assign mul_finished = fin_q | stray;
  assign mul_result   = res_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // A response must never coincide with a grant or start pulse
  always @(negedge sys_clk)
    if (rsp_valid) chk("rsp_exclusive", {30'd0, |ack, mul_start}, 32'd0);

  typedef struct {
    logic [3:0]  rq;
    logic [15:0] a;
    logic [15:0] b;
    int          lt;
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } row_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  row_t tbl[17];
  exp_t sb[$];

  task automatic run_row(input row_t r);
    int   n;
    int   unst;
    int   exp_cyc;
    exp_t e;
    logic [3:0] ea;
    req  = r.rq;
    op_a = {4{r.a}};
    op_b = {4{r.b}};
    lat  = r.lt;
    sb.push_back('{r.id, r.data, r.err});
    ea = 4'b0001 << r.id;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (ack == 4'b0 && n < 10);
    chk("ack_grant", 32'(ack), 32'(ea));
    chk("start_hi", 32'(mul_start), 32'd1);
    chk("id_at_grant", 32'(rsp_id), 32'(r.id));
    chk("no_rsp_at_grant", 32'(rsp_valid), 32'd0);
    @(negedge sys_clk);
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("start_pulse", 32'(mul_start), 32'd0);
    chk("busy_hi", 32'(busy), 32'd1);
    n = 0;
    unst = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (mul_in1 !== r.a || mul_in2 !== r.b) unst++;
    end while (!rsp_valid && n < int'(TIMEOUT) + 10);
    exp_cyc = r.err ? int'(TIMEOUT) : r.lt + 1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(n), 32'(exp_cyc));
    chk("operands_stable", 32'(unst), 32'd0);
    chk("busy_lo_at_rsp", 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got response want none queued");
    end else begin
      e = sb.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    chk({tag, "_mul_in"}, {mul_in1, mul_in2}, 32'd0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{4'b0101, 16'h0007, 16'h0006,  3, 2'd0, 32'h0000002A, 1'b0};
    tbl[1]  = '{4'b0101, 16'hFFF9, 16'h0006,  1, 2'd2, 32'hFFFFFFD6, 1'b0};
    tbl[2]  = '{4'b0101, 16'h0000, 16'h007B,  2, 2'd0, 32'h00000000, 1'b0};
    tbl[3]  = '{4'b1111, 16'h03E8, 16'h03E8,  5, 2'd1, 32'h000F4240, 1'b0};
    tbl[4]  = '{4'b1111, 16'hFFFF, 16'hFFFF,  4, 2'd2, 32'h00000001, 1'b0};
    tbl[5]  = '{4'b1111, 16'h00FF, 16'hFF00,  2, 2'd3, 32'hFFFF0100, 1'b0};
    tbl[6]  = '{4'b1111, 16'h000C, 16'h000C,  1, 2'd0, 32'h00000090, 1'b0};
    tbl[7]  = '{4'b0001, 16'h0003, 16'hFFFB,  3, 2'd0, 32'hFFFFFFF1, 1'b0};
    tbl[8]  = '{4'b0001, 16'h8000, 16'h8000,  6, 2'd0, 32'h40000000, 1'b0};
    tbl[9]  = '{4'b0010, 16'h7FFF, 16'h8000,  8, 2'd1, 32'hC0008000, 1'b0};
    tbl[10] = '{4'b0100, 16'h0004, 16'h0004,  0, 2'd2, 32'h00000000, 1'b1};
    tbl[11] = '{4'b1000, 16'hFFFE, 16'hFFFD,  2, 2'd3, 32'h00000006, 1'b0};
    tbl[12] = '{4'b0011, 16'h0005, 16'h0005, 39, 2'd0, 32'h00000019, 1'b0};
    tbl[13] = '{4'b0110, 16'h0009, 16'h0009, 40, 2'd1, 32'h00000000, 1'b1};
    tbl[14] = '{4'b0110, 16'hFFF7, 16'h0009,  1, 2'd2, 32'hFFFFFFAF, 1'b0};
    tbl[15] = '{4'b1001, 16'h000B, 16'hFFF5,  2, 2'd3, 32'hFFFFFF87, 1'b0};
    tbl[16] = '{4'b1010, 16'h0064, 16'hFFFD,  2, 2'd1, 32'hFFFFFED4, 1'b0};

    sys_rst = 1'b1;
    req = '0; op_a = '0; op_b = '0; lat = 0; stray = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst = 1'b0;

    for (int i = 0; i < 15; i++) run_row(tbl[i]);

    // Stray finish pulse while idle must be ignored
    req = '0;
    @(negedge sys_clk);
    stray = 1'b1;
    @(negedge sys_clk);
    stray = 1'b0;
    chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_idle", 32'(busy), 32'd0);
    chk("stray_no_ack", 32'(ack), 32'd0);
    @(negedge sys_clk);
    chk("stray_no_rsp2", 32'(rsp_valid), 32'd0);
    run_row(tbl[15]);

    // Reset in the middle of a stalled multiply
    req  = 4'b0100;
    op_a = {4{16'h0021}};
    op_b = {4{16'h0022}};
    lat  = 0;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (ack == 4'b0 && n < 10);
    chk("rst_seq_ack", 32'(ack), 32'b0100);
    req = '0;
    repeat (5) @(negedge sys_clk);
    chk("rst_seq_busy", 32'(busy), 32'd1);
    #2 sys_rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    run_row(tbl[16]);

    req = '0;
    @(negedge sys_clk);
    chk("final_no_rsp", 32'(rsp_valid), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
